// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//
// Command-side master for an 18-bit ALU. The sequencer takes one operation
// request over a valid/ready handshake and drives the ALU operand and control
// inputs. It waits for the ALU's registered result, captures the result and
// flags, and returns them over a valid/ready response. Divide/modulus by zero
// and illegal opcodes are trapped before they reach the ALU.
//
// Ports
//   clk, rst             single rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_a, req_b         operands (WIDTH bits)
//   req_op               ALU ctrl code: [3] = shift-left-1, [2:0] = op 0..6
//   rsp_valid/rsp_ready  response handshake
//   rsp_result           captured ALU result (WIDTH+1 bits)
//   rsp_flags            {ovf, AgtB, N, Z} captured with the result
//   rsp_err              1 = op trapped (div/mod by zero or illegal op)
//   alu_datA/B, alu_ctrl operand/control drive to the ALU
//   alu_result           registered ALU result
//   alu_ovf/AgtB/N/Z     combinational ALU flags
//   busy                 sequencer not idle
//   op_count             completed responses, wrapping
//   err_count            trapped responses, saturating at 255
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int WIDTH = 18,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [3:0]       req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH:0]   rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_datA,
    output logic [WIDTH-1:0] alu_datB,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH:0]   alu_result,
    input  logic             alu_ovf,
    input  logic             alu_AgtB,
    input  logic             alu_N,
    input  logic             alu_Z,
    output logic             busy,
    output logic [CNT_W-1:0] op_count,
    output logic [7:0]       err_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_RESP
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_alu_datA;
    logic [WIDTH-1:0] r_alu_datB;
    logic [3:0]       r_alu_ctrl;
    logic [WIDTH:0]   r_rsp_result;
    logic [3:0]       r_rsp_flags;
    logic             r_rsp_err;
    logic [CNT_W-1:0] r_op_count;
    logic [7:0]       r_err_count;

    logic w_accept;
    logic w_trap;
    logic w_rsp_fire;
    logic w_div_op;

    assign w_accept   = req_valid && (r_state == ST_IDLE);
    assign w_div_op   = (req_op[2:0] == 3'd3) || (req_op[2:0] == 3'd4);
    // Opcode 7 is illegal; div/mod with a zero divisor never reaches the ALU.
    assign w_trap     = (req_op[2:0] == 3'd7) || (w_div_op && (req_b == '0));
    assign w_rsp_fire = (r_state == ST_RESP) && rsp_ready;

    // NOTE: every output of this block gets a default first, so no path can
    // leave w_state_next unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_trap ? ST_RESP : ST_DRIVE;
                end
            end
            ST_DRIVE:  w_state_next = ST_SAMPLE;
            ST_SAMPLE: w_state_next = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand/control drive: loaded only on a non-trapped accept and held
    // until the next one, so the ALU's combinational flags are stable when
    // they are sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_datA <= '0;
            r_alu_datB <= '0;
            r_alu_ctrl <= '0;
        end else if (w_accept && !w_trap) begin
            r_alu_datA <= req_a;
            r_alu_datB <= req_b;
            r_alu_ctrl <= req_op;
        end
    end

    // Response capture. A trap writes a zero result with the error bit set.
    // A real op is captured in SAMPLE, one cycle after the ALU registered it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_rsp_err    <= 1'b0;
        end else if (w_accept && w_trap) begin
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_rsp_err    <= 1'b1;
        end else if (r_state == ST_SAMPLE) begin
            r_rsp_result <= alu_result;
            r_rsp_flags  <= {alu_ovf, alu_AgtB, alu_N, alu_Z};
            r_rsp_err    <= 1'b0;
        end
    end

    // Statistics, updated on each completed response handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_count  <= '0;
            r_err_count <= '0;
        end else if (w_rsp_fire) begin
            r_op_count <= r_op_count + 1'b1;
            if (r_rsp_err && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign rsp_valid  = (r_state == ST_RESP);
    assign busy       = (r_state != ST_IDLE);
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign rsp_err    = r_rsp_err;
    assign alu_datA   = r_alu_datA;
    assign alu_datB   = r_alu_datB;
    assign alu_ctrl   = r_alu_ctrl;
    assign op_count   = r_op_count;
    assign err_count  = r_err_count;

endmodule
